// File: rtl/seq_detector.sv
// Serial pattern detector stepped by a synchronised divided-clock level on clkin.
// SEQ_DET_OVERLAP_EN: when defined, a match's suffix may start the next match.
module seq_detector #(
    parameter int unsigned    LEN     = 5,
    parameter logic [LEN-1:0] PATTERN = LEN'(5'b10010),
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             step_clk,
    input  logic             din,
    output logic             hit,
    output logic             hit_led,
    output logic [CNT_W-1:0] hit_count,
    output logic [LEN-1:0]   shift_q
);

    localparam int unsigned FILL_W = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    logic             r_step_s1;
    logic             r_step_s2;
    logic             r_step_s3;
    logic             r_din_s1;
    logic             r_din_s2;
    logic [1:0]       r_vld;
    logic             r_armed;
    logic [LEN-1:0]   r_shift;
    logic [FILL_W-1:0] r_fill;
    logic             r_hit;
    logic             r_hit_led;
    logic [CNT_W-1:0] r_hit_count;

    logic             w_step_rise;
    logic [LEN-1:0]   w_shift_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic             w_match;

    // Equal-depth synchronisers; r_vld marks when s2 carries a post-reset sample.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
            r_step_s3 <= 1'b0;
            r_din_s1  <= 1'b0;
            r_din_s2  <= 1'b0;
            r_vld     <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_step_s1 <= step_clk;
            r_step_s2 <= r_step_s1;
            r_step_s3 <= r_step_s2;
            r_din_s1  <= din;
            r_din_s2  <= r_din_s1;
            r_vld     <= {r_vld[0], 1'b1};
            r_armed   <= r_armed | (r_vld[1] & ~r_step_s2);
        end
    end

    // A step_clk already high at reset release must go low before it can step.
    assign w_step_rise = r_step_s2 & ~r_step_s3 & r_armed;
    assign w_shift_nxt = {r_shift[LEN-2:0], r_din_s2};
    assign w_fill_nxt  = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
    assign w_match     = (w_shift_nxt == PATTERN) && (w_fill_nxt == FILL_FULL);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_fill      <= '0;
            r_hit       <= 1'b0;
            r_hit_led   <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_hit <= 1'b0;
            if (w_step_rise) begin
                r_shift   <= w_shift_nxt;
                r_hit     <= w_match;
                r_hit_led <= w_match;
                if (w_match && (r_hit_count != '1)) begin
                    r_hit_count <= r_hit_count + CNT_W'(1);
                end
`ifdef SEQ_DET_OVERLAP_EN
                r_fill <= w_fill_nxt;
`else
                r_fill <= w_match ? '0 : w_fill_nxt;
`endif
            end
        end
    end

    assign hit       = r_hit;
    assign hit_led   = r_hit_led;
    assign hit_count = r_hit_count;
    assign shift_q   = r_shift;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: default, preload-pattern and narrow-counter instances.
module tb_seq_detector;

    logic clk;
    logic rst_n;
    logic step_clk;
    logic din;

    logic       hit_a, led_a;
    logic [7:0] cnt_a;
    logic [4:0] sh_a;
    logic       hit_b, led_b;
    logic [7:0] cnt_b;
    logic [4:0] sh_b;
    logic       hit_c, led_c;
    logic [1:0] cnt_c;
    logic [4:0] sh_c;

    int errors = 0;
    int checks = 0;
    int hc_a = 0;
    int hc_b = 0;
    int hc_c = 0;

    seq_detector u_dut (
        .clkin(clk), .rst_n(rst_n), .step_clk(step_clk), .din(din),
        .hit(hit_a), .hit_led(led_a), .hit_count(cnt_a), .shift_q(sh_a)
    );

    seq_detector #(.LEN(5), .PATTERN(5'b00010), .CNT_W(8)) u_fill (
        .clkin(clk), .rst_n(rst_n), .step_clk(step_clk), .din(din),
        .hit(hit_b), .hit_led(led_b), .hit_count(cnt_b), .shift_q(sh_b)
    );

    seq_detector #(.LEN(5), .PATTERN(5'b10010), .CNT_W(2)) u_sat (
        .clkin(clk), .rst_n(rst_n), .step_clk(step_clk), .din(din),
        .hit(hit_c), .hit_led(led_c), .hit_count(cnt_c), .shift_q(sh_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count hit-pulse cycles per instance, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hc_a = 0;
            hc_b = 0;
            hc_c = 0;
        end else begin
            hc_a = hc_a + (hit_a ? 1 : 0);
            hc_b = hc_b + (hit_b ? 1 : 0);
            hc_c = hc_c + (hit_c ? 1 : 0);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step_clk = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_step(input logic b);
        @(negedge clk);
        din = b;
        step_clk = 1'b1;
        repeat (3) @(negedge clk);
        step_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) do_step(bits[i]);
    endtask

    // din toggles every cycle except at the clkin edge that samples the step.
    task automatic noise_step(input logic b);
        @(negedge clk);
        din = b;
        step_clk = 1'b1;
        repeat (3) begin
            @(negedge clk);
            din = ~din;
        end
        step_clk = 1'b0;
        repeat (3) begin
            @(negedge clk);
            din = ~din;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (sh_a !== 5'b0) begin errors++; $display("FAIL reset_shift: got %b expected 00000", sh_a); end
        checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt_a); end
        checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit_a); end
        checks++; if (led_a !== 1'b0) begin errors++; $display("FAIL reset_led: got %b expected 0", led_a); end
        apply_reset();
        feed(16'b10010, 5);
        checks++; if (cnt_a !== 8'd1) begin errors++; $display("FAIL pre_reset_count: got %0d expected 1", cnt_a); end
        @(negedge clk);
        step_clk = 1'b1;
        din = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({hit_a, led_a, cnt_a, sh_a} !== 15'd0) begin errors++; $display("FAIL async_clear_a: got %h expected 0", {hit_a, led_a, cnt_a, sh_a}); end
        checks++; if ({hit_b, led_b, cnt_b, sh_b} !== 15'd0) begin errors++; $display("FAIL async_clear_b: got %h expected 0", {hit_b, led_b, cnt_b, sh_b}); end
        checks++; if ({hit_c, led_c, cnt_c, sh_c} !== 9'd0) begin errors++; $display("FAIL async_clear_c: got %h expected 0", {hit_c, led_c, cnt_c, sh_c}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (sh_a !== 5'b0) begin errors++; $display("FAIL held_high_after_reset: got %b expected 00000", sh_a); end
        step_clk = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sh_a !== 5'b0) begin errors++; $display("FAIL fall_no_step: got %b expected 00000", sh_a); end
        step_clk = 1'b1;
        repeat (3) @(negedge clk);
        step_clk = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sh_a !== 5'b00001) begin errors++; $display("FAIL first_fresh_step: got %b expected 00001", sh_a); end
    endtask

    task automatic test_basic();
        apply_reset();
        feed(16'b1001, 4);
        @(negedge clk);
        din = 1'b0;
        step_clk = 1'b1;
        @(negedge clk);
        checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL hit_lat_c1: got %b expected 0", hit_a); end
        @(negedge clk);
        checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL hit_lat_c2: got %b expected 0", hit_a); end
        @(negedge clk);
        checks++; if (hit_a !== 1'b1) begin errors++; $display("FAIL hit_lat_c3: got %b expected 1", hit_a); end
        @(negedge clk);
        checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL hit_width: got %b expected 0", hit_a); end
        step_clk = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sh_a !== 5'b10010) begin errors++; $display("FAIL basic_shift: got %b expected 10010", sh_a); end
        checks++; if (cnt_a !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", cnt_a); end
        checks++; if (led_a !== 1'b1) begin errors++; $display("FAIL basic_led_on: got %b expected 1", led_a); end
        checks++; if (hc_a !== 1) begin errors++; $display("FAIL basic_pulse_cycles: got %0d expected 1", hc_a); end
        do_step(1'b1);
        checks++; if (led_a !== 1'b0) begin errors++; $display("FAIL basic_led_off: got %b expected 0", led_a); end
        checks++; if (sh_a !== 5'b00101) begin errors++; $display("FAIL basic_shift_next: got %b expected 00101", sh_a); end
    endtask

    task automatic test_fill_guard();
        apply_reset();
        feed(16'b010, 3);
        checks++; if (sh_b !== 5'b00010) begin errors++; $display("FAIL fill_shift: got %b expected 00010", sh_b); end
        checks++; if (cnt_b !== 8'd0) begin errors++; $display("FAIL fill_no_count: got %0d expected 0", cnt_b); end
        checks++; if (hc_b !== 0) begin errors++; $display("FAIL fill_no_pulse: got %0d expected 0", hc_b); end
        feed(16'b00010, 5);
        checks++; if (cnt_b !== 8'd1) begin errors++; $display("FAIL fill_full_count: got %0d expected 1", cnt_b); end
        checks++; if (hc_b !== 1) begin errors++; $display("FAIL fill_full_pulse: got %0d expected 1", hc_b); end
    endtask

    task automatic test_overlap();
        int exp_hits;
`ifdef SEQ_DET_OVERLAP_EN
        exp_hits = 2;
`else
        exp_hits = 1;
`endif
        apply_reset();
        feed(16'b10010010, 8);
        checks++; if (int'(cnt_a) !== exp_hits) begin errors++; $display("FAIL overlap_count: got %0d expected %0d", cnt_a, exp_hits); end
        checks++; if (hc_a !== exp_hits) begin errors++; $display("FAIL overlap_pulses: got %0d expected %0d", hc_a, exp_hits); end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 5; k++) feed(16'b10010, 5);
        checks++; if (cnt_c !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d expected 3", cnt_c); end
        checks++; if (hc_c !== 5) begin errors++; $display("FAIL sat_pulses: got %0d expected 5", hc_c); end
        feed(16'b10010, 5);
        checks++; if (cnt_c !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d expected 3", cnt_c); end
        checks++; if (cnt_a !== 8'd6) begin errors++; $display("FAIL wide_count: got %0d expected 6", cnt_a); end
    endtask

    task automatic test_noise();
        apply_reset();
        noise_step(1'b1);
        noise_step(1'b1);
        noise_step(1'b0);
        noise_step(1'b1);
        noise_step(1'b0);
        checks++; if (sh_a !== 5'b11010) begin errors++; $display("FAIL noise_shift: got %b expected 11010", sh_a); end
        checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL noise_count: got %0d expected 0", cnt_a); end
    endtask

    task automatic test_hold_high();
        apply_reset();
        @(negedge clk);
        din = 1'b1;
        step_clk = 1'b1;
        @(negedge clk);
        din = 1'b0;
        repeat (99) @(negedge clk);
        step_clk = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (sh_a !== 5'b00001) begin errors++; $display("FAIL hold_single_step: got %b expected 00001", sh_a); end
    endtask

    initial begin
        rst_n = 1'b0;
        step_clk = 1'b0;
        din = 1'b0;
        test_reset();
        test_basic();
        test_fill_guard();
        test_overlap();
        test_saturation();
        test_noise();
        test_hold_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
